// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - push-button debouncer with click pulses; BUTTON_REPEAT_EN adds hold auto-repeat
module button_debounce #(
  parameter logic [31:0] CLICK_COUNT   = 32'd2500000,
  parameter logic [31:0] REPEAT_DELAY  = 32'd25000000,
  parameter logic [31:0] REPEAT_PERIOD = 32'd5000000,
  parameter logic        ACTIVE_LOW    = 1'b1
) (
  input  logic sys_clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic click,
  output logic pressed
);

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;

  // Zero counts would make a state unreachable; nothing here can recover from that.
  if (CLICK_COUNT == 32'd0 || REPEAT_DELAY == 32'd0 || REPEAT_PERIOD == 32'd0) begin : g_invalid_params
  end

  logic        sync1, sync2, p;
  state_t      state, state_nxt;
  logic [31:0] cnt, cnt_nxt;
  logic        click_nxt, pressed_nxt;

  // Released level of the raw pin equals ACTIVE_LOW, so the synchronizer resets to it.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= ACTIVE_LOW;
      sync2 <= ACTIVE_LOW;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  assign p = sync2 ^ ACTIVE_LOW;

`ifdef BUTTON_REPEAT_EN
  logic [31:0] rcnt, rcnt_nxt;
  logic        rep_flag, rep_flag_nxt;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      rcnt     <= 32'd0;
      rep_flag <= 1'b0;
    end else begin
      rcnt     <= rcnt_nxt;
      rep_flag <= rep_flag_nxt;
    end
  end
`endif

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= 32'd0;
      click   <= 1'b0;
      pressed <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      click   <= click_nxt;
      pressed <= pressed_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    click_nxt = 1'b0;
`ifdef BUTTON_REPEAT_EN
    rcnt_nxt     = rcnt;
    rep_flag_nxt = rep_flag;
`endif
    case (state)
      IDLE: begin
        if (p) begin
          state_nxt = PRESS_WAIT;
          cnt_nxt   = 32'd1;
        end
      end
      PRESS_WAIT: begin
        if (!p) begin
          state_nxt = IDLE;
          cnt_nxt   = 32'd0;
        end else if (cnt == CLICK_COUNT) begin
          state_nxt = HELD;
          click_nxt = 1'b1;
          cnt_nxt   = 32'd0;
`ifdef BUTTON_REPEAT_EN
          rcnt_nxt     = 32'd1;
          rep_flag_nxt = 1'b0;
`endif
        end else begin
          cnt_nxt = cnt + 32'd1;
        end
      end
      HELD: begin
        if (!p) begin
          state_nxt = RELEASE_WAIT;
          cnt_nxt   = 32'd1;
`ifdef BUTTON_REPEAT_EN
          rcnt_nxt     = 32'd0;
          rep_flag_nxt = 1'b0;
`endif
        end else begin
`ifdef BUTTON_REPEAT_EN
          // First repeat waits REPEAT_DELAY, every later one REPEAT_PERIOD.
          if (rcnt == (rep_flag ? REPEAT_PERIOD : REPEAT_DELAY)) begin
            click_nxt    = 1'b1;
            rcnt_nxt     = 32'd1;
            rep_flag_nxt = 1'b1;
          end else begin
            rcnt_nxt = rcnt + 32'd1;
          end
`endif
        end
      end
      RELEASE_WAIT: begin
        if (p) begin
          state_nxt = HELD;
          cnt_nxt   = 32'd0;
`ifdef BUTTON_REPEAT_EN
          rcnt_nxt     = 32'd1;
          rep_flag_nxt = 1'b0;
`endif
        end else if (cnt == CLICK_COUNT) begin
          state_nxt = IDLE;
          cnt_nxt   = 32'd0;
        end else begin
          cnt_nxt = cnt + 32'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 32'd0;
      end
    endcase
    pressed_nxt = (state_nxt == HELD) || (state_nxt == RELEASE_WAIT);
  end

endmodule
